// File: rtl/scope_capture.sv
// scope_capture: pre/post-trigger ring-buffer capture with oldest-first valid/ready readout.
// Define SCOPE_CAPTURE_CHANGE_ONLY_EN to store only changed samples, tagged with cycle deltas.
module scope_capture #(
    parameter int NSIG = 1,
    parameter int DEPTH_LOG2 = 8,
    parameter int TW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSIG-1:0]       sigin,
    input  logic                  triggered,
    input  logic                  changed,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DEPTH_LOG2-1:0] npost,
    output logic                  armed,
    output logic                  done,
    output logic [DEPTH_LOG2-1:0] trig_pos,
    output logic [TW+NSIG-1:0]    rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last
);
    localparam int AW = DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, READ} state_t;
    state_t state;
    logic [TW+NSIG-1:0] mem [DEPTH];
    logic [AW-1:0] np, npre, wptr, raddr, pcnt;
    logic [AW:0] count, rcnt;
    logic [TW-1:0] delta;
    logic capture, store, trig, rd_started, fetch;
    assign npre = ~np;
    assign capture = (state == PRE || state == WAIT || state == POST) && !abort;
    assign trig = state == WAIT && triggered && !abort;
    assign fetch = state == READ && rd_started && rcnt != '0 && (!rd_valid || rd_ready);
`ifdef SCOPE_CAPTURE_CHANGE_ONLY_EN
    logic [TW-1:0] dcnt;
    assign delta = dcnt + 1'b1;
    // a saturated gap forces a store so static inputs still advance the capture
    assign store = capture && (changed || trig || &delta);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dcnt <= '0;
        else if (state == IDLE || store) dcnt <= '0;
        else dcnt <= delta;
`else
    logic unused_changed;
    assign unused_changed = changed;
    assign delta = TW'(1);
    assign store = capture;
`endif
    always_ff @(posedge clk)
        if (store) mem[wptr] <= {delta, sigin};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
            done <= 1'b0;
            rd_valid <= 1'b0;
            rd_last <= 1'b0;
            rd_data <= '0;
            trig_pos <= '0;
            np <= '0;
            wptr <= '0;
            raddr <= '0;
            pcnt <= '0;
            count <= '0;
            rcnt <= '0;
            rd_started <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            armed <= 1'b0;
            done <= 1'b0;
            rd_valid <= 1'b0;
            rd_last <= 1'b0;
            rd_started <= 1'b0;
        end else begin
            if (store) begin
                wptr <= wptr + 1'b1;
                count <= count[AW] ? count : count + 1'b1;
            end
            case (state)
                IDLE: if (arm) begin
                    np <= npost;
                    pcnt <= npost;
                    wptr <= '0;
                    count <= '0;
                    state <= (npost == '1) ? WAIT : PRE;
                    armed <= 1'b1;
                end
                PRE: if (store && count + 1'b1 == {1'b0, npre}) state <= WAIT;
                WAIT: if (trig) begin
                    // trigger's index among the entries that survive the post window
                    trig_pos <= (count >= {1'b0, npre}) ? npre : count[AW-1:0];
                    state <= (np == '0) ? READ : POST;
                    armed <= np != '0;
                    done <= np == '0;
                end
                POST: if (store) begin
                    pcnt <= pcnt - 1'b1;
                    if (pcnt == AW'(1)) begin
                        state <= READ;
                        armed <= 1'b0;
                        done <= 1'b1;
                    end
                end
                READ: begin
                    if (!rd_started) begin
                        rd_started <= 1'b1;
                        raddr <= wptr - count[AW-1:0];
                        rcnt <= count;
                    end else if (fetch) begin
                        rd_data <= mem[raddr];
                        raddr <= raddr + 1'b1;
                        rcnt <= rcnt - 1'b1;
                        rd_valid <= 1'b1;
                        rd_last <= rcnt == (AW+1)'(1);
                    end else if (rd_valid && rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_last <= 1'b0;
                        if (rd_last) begin
                            state <= IDLE;
                            done <= 1'b0;
                            rd_started <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: directed checks of capture windows, trigger position, readout and abort/reset.
module tb_scope_capture;
    localparam int NSIG = 8, DL = 4, TW = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [NSIG-1:0] sigin = '0;
    logic triggered = 1'b0, changed = 1'b0, arm = 1'b0, abort = 1'b0, rd_ready = 1'b0;
    logic [DL-1:0] npost = '0;
    logic armed, done, rd_valid, rd_last;
    logic [DL-1:0] trig_pos;
    logic [TW+NSIG-1:0] rd_data;
    int tests = 0, fails = 0;
    logic [TW+NSIG-1:0] rdq [64];
    logic lastq [64];
    int n, unstable;

    scope_capture #(.NSIG(NSIG), .DEPTH_LOG2(DL), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .sigin(sigin), .triggered(triggered), .changed(changed),
        .arm(arm), .abort(abort), .npost(npost), .armed(armed), .done(done),
        .trig_pos(trig_pos), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int np, input int trig_at, input bit hold);
        npost = DL'(np);
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            sigin = NSIG'(i);
            triggered = hold || i == trig_at;
            step();
        end
        triggered = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0,1
    task automatic read_all(input int mode, output int cnt, output int unst);
        logic [TW+NSIG-1:0] prev = '0;
        bit prev_stall = 1'b0;
        cnt = 0;
        unst = 0;
        for (int k = 0; k < 200 && cnt < 64; k++) begin
            rd_ready = (mode == 0) || (k % 4 == 0) || (k % 4 == 3);
            if (prev_stall && rd_data !== prev) unst++;
            if (rd_valid && rd_ready) begin
                rdq[cnt] = rd_data;
                lastq[cnt] = rd_last;
                cnt++;
            end
            prev_stall = rd_valid && !rd_ready;
            prev = rd_data;
            step();
            if (cnt > 0 && lastq[cnt-1]) break;
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        tests++;
        if ({armed, done, rd_valid, rd_last} !== 4'b0 || rd_data !== '0 || trig_pos !== '0) begin
            fails++;
            $display("FAIL reset: armed=%b done=%b valid=%b last=%b data=%h tp=%0d, want all 0",
                     armed, done, rd_valid, rd_last, rd_data, trig_pos);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_capture();
        capture(5, 20, 1'b0);
        tests++;
        if (done !== 1'b1 || trig_pos !== 4'd10) begin
            fails++;
            $display("FAIL full_trig_pos: done=%b tp=%0d, want done=1 tp=10", done, trig_pos);
        end
        tests++;
        if (rd_valid !== 1'b0 || armed !== 1'b0) begin
            fails++;
            $display("FAIL full_enter_read: valid=%b armed=%b, want 0 0", rd_valid, armed);
        end
        step();
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_latency1: valid=%b, want 0", rd_valid);
        end
        step();
        tests++;
        if (rd_valid !== 1'b1) begin
            fails++;
            $display("FAIL full_latency2: valid=%b, want 1", rd_valid);
        end
        read_all(0, n, unstable);
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL full_count: got %0d entries, want 16", n);
        end
        for (int i = 0; i < n && i < 16; i++) begin
            tests++;
            if (rdq[i] !== {4'd1, 8'(10 + i)} || lastq[i] !== (i == 15)) begin
                fails++;
                $display("FAIL full_entry%0d: data=%h last=%b, want data=%h last=%b",
                         i, rdq[i], lastq[i], {4'd1, 8'(10 + i)}, i == 15);
            end
        end
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL full_idle: done=%b, want 0", done);
        end
    endtask

    task automatic test_early_trigger();
        capture(5, 0, 1'b1);
        tests++;
        if (trig_pos !== 4'd10) begin
            fails++;
            $display("FAIL early_trig_pos: tp=%0d, want 10", trig_pos);
        end
        read_all(0, n, unstable);
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL early_count: got %0d, want 16", n);
        end
        for (int i = 0; i < n && i < 16; i++) begin
            tests++;
            if (rdq[i][NSIG-1:0] !== 8'(i)) begin
                fails++;
                $display("FAIL early_entry%0d: sample=%0d, want %0d", i, rdq[i][NSIG-1:0], i);
            end
        end
    endtask

    task automatic test_backpressure();
        capture(3, 12, 1'b0);
        tests++;
        if (trig_pos !== 4'd12) begin
            fails++;
            $display("FAIL bp_trig_pos: tp=%0d, want 12", trig_pos);
        end
        read_all(1, n, unstable);
        tests++;
        if (n != 16 || unstable != 0) begin
            fails++;
            $display("FAIL bp_stream: got %0d entries %0d unstable, want 16 entries 0 unstable", n, unstable);
        end
        for (int i = 0; i < n && i < 16; i++) begin
            tests++;
            if (rdq[i] !== {4'd1, 8'(i)} || lastq[i] !== (i == 15)) begin
                fails++;
                $display("FAIL bp_entry%0d: data=%h last=%b, want data=%h last=%b",
                         i, rdq[i], lastq[i], {4'd1, 8'(i)}, i == 15);
            end
        end
        tests++;
        if (done !== 1'b0 || rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_idle: done=%b valid=%b, want 0 0", done, rd_valid);
        end
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        npost = 4'd5;
        arm = 1'b1;
        step();
        arm = 1'b0;
        tests++;
        if (armed !== 1'b1) begin
            fails++;
            $display("FAIL abort_armed: armed=%b, want 1", armed);
        end
        for (int i = 0; i < 14; i++) begin
            sigin = NSIG'(i);
            triggered = i == 12;
            step();
        end
        triggered = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++;
        if (armed !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: armed=%b done=%b, want 0 0", armed, done);
        end
        rd_ready = 1'b1;
        repeat (20) begin
            step();
            if (rd_valid || done) seen = 1'b1;
        end
        rd_ready = 1'b0;
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL abort_no_read: readout seen=1, want 0");
        end
        arm = 1'b1;
        abort = 1'b1;
        step();
        arm = 1'b0;
        abort = 1'b0;
        tests++;
        if (armed !== 1'b0) begin
            fails++;
            $display("FAIL arm_abort: armed=%b, want 0", armed);
        end
    endtask

    task automatic test_reset_mid_read();
        capture(5, 20, 1'b0);
        rd_ready = 1'b1;
        repeat (4) step();
        tests++;
        if (rd_valid !== 1'b1 || trig_pos !== 4'd10) begin
            fails++;
            $display("FAIL rst_pre: valid=%b tp=%0d, want 1 10", rd_valid, trig_pos);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({armed, done, rd_valid, rd_last} !== 4'b0 || rd_data !== '0 || trig_pos !== '0) begin
            fails++;
            $display("FAIL rst_mid_read: armed=%b done=%b valid=%b last=%b data=%h tp=%0d, want all 0",
                     armed, done, rd_valid, rd_last, rd_data, trig_pos);
        end
        rd_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        tests++;
        if (done !== 1'b0 || rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_after: done=%b valid=%b, want 0 0", done, rd_valid);
        end
    endtask

    task automatic test_npost_clamp();
        capture(15, 0, 1'b1);
        tests++;
        if (trig_pos !== 4'd0 || done !== 1'b1) begin
            fails++;
            $display("FAIL clamp_trig_pos: tp=%0d done=%b, want 0 1", trig_pos, done);
        end
        read_all(0, n, unstable);
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL clamp_count: got %0d, want 16", n);
        end
        for (int i = 0; i < n && i < 16; i++) begin
            tests++;
            if (rdq[i][NSIG-1:0] !== 8'(i) || lastq[i] !== (i == 15)) begin
                fails++;
                $display("FAIL clamp_entry%0d: sample=%0d last=%b, want %0d %b",
                         i, rdq[i][NSIG-1:0], lastq[i], i, i == 15);
            end
        end
    endtask

    task automatic test_change_only();
        logic [TW-1:0] d;
        logic [NSIG-1:0] s;
        npost = 4'd12;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int k = 1; k < 400 && !done; k++) begin
            sigin = NSIG'(k);
            changed = k == 3 || k == 40;
            triggered = k == 40;
            step();
        end
        changed = 1'b0;
        triggered = 1'b0;
        tests++;
        if (trig_pos !== 4'd3 || done !== 1'b1) begin
            fails++;
            $display("FAIL chg_trig_pos: tp=%0d done=%b, want 3 1", trig_pos, done);
        end
        read_all(0, n, unstable);
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL chg_count: got %0d, want 16", n);
        end
        for (int i = 0; i < n && i < 16; i++) begin
            d = (i == 0) ? 4'd3 : (i == 3) ? 4'd7 : 4'd15;
            s = (i == 0) ? 8'd3 : (i == 1) ? 8'd18 : (i == 2) ? 8'd33 : 8'(40 + 15 * (i - 3));
            tests++;
            if (rdq[i] !== {d, s}) begin
                fails++;
                $display("FAIL chg_entry%0d: data=%h, want %h", i, rdq[i], {d, s});
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef SCOPE_CAPTURE_CHANGE_ONLY_EN
        test_change_only();
`else
        test_full_capture();
        test_early_trigger();
        test_backpressure();
        test_abort();
        test_reset_mid_read();
        test_npost_clamp();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
